char_buf_writer: RTL and testbench



---
 rtl/char_buf_writer.sv | 124 ++++++++++++
 tb/tb_char_buf_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/char_buf_writer.sv
// Byte-stream writer for a 16x16 text cell buffer with a combinational read port.
// Optional blinking cursor overlay is enabled by defining CHAR_BUF_CURSOR_EN.
module char_buf_writer #(
  parameter logic [6:0]  CLEAR_CHAR   = 7'h20
`ifdef CHAR_BUF_CURSOR_EN
  , parameter logic [6:0]  CURSOR_GLYPH = 7'h7F
  , parameter logic [24:0] BLINK_DIV    = 25'd20_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  output logic [7:0] cursor_xy,
  output logic       busy
);

  // state   | meaning
  // S_CLEAR | writing CLEAR_CHAR to cell clr_cnt_q, one per cycle
  // S_RUN   | accepting and interpreting bytes at the cursor
  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t     state_q, state_d;
  logic [7:0] clr_cnt_q, clr_cnt_d;
  logic [7:0] cursor_q, cursor_d;
  logic [7:0] bs_pos;
  logic       we;
  logic [7:0] waddr;
  logic [6:0] wdata;
  logic [6:0] mem [256];

  assign bs_pos    = (cursor_q == 8'h00) ? 8'h00 : cursor_q - 8'd1;
  assign cursor_xy = cursor_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= 8'h00;
      cursor_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      cursor_q  <= cursor_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    cursor_d  = cursor_q;
    we        = 1'b0;
    waddr     = 8'h00;
    wdata     = CLEAR_CHAR;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_CLEAR: begin
        busy      = 1'b1;
        we        = 1'b1;
        waddr     = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 8'd1;
        if (clr_cnt_q == 8'hFF) state_d = S_RUN;
      end
      S_RUN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            we       = 1'b1;
            waddr    = cursor_q;
            wdata    = in_data[6:0];
            // 8-bit increment gives col wrap into next row and {15,15} -> {0,0}
            cursor_d = cursor_q + 8'd1;
          end else begin
            case (in_data)
              8'h0A: cursor_d = {cursor_q[7:4] + 4'd1, 4'h0};
              8'h0D: cursor_d = {cursor_q[7:4], 4'h0};
              8'h08: begin
                cursor_d = bs_pos;
                we       = 1'b1;
                waddr    = bs_pos;
              end
              8'h0C: begin
                cursor_d  = 8'h00;
                clr_cnt_d = 8'h00;
                state_d   = S_CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef CHAR_BUF_CURSOR_EN
  logic [24:0] blink_cnt_q;
  logic        blink_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= 25'd0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BLINK_DIV - 25'd1) begin
      blink_cnt_q <= 25'd0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 25'd1;
    end
  end

  assign char_code = (blink_q && !busy && char_xy == cursor_q) ? CURSOR_GLYPH : mem[char_xy];
`else
  assign char_code = mem[char_xy];
`endif

endmodule

// File: tb/tb_char_buf_writer.sv
// Randomized scoreboard bench for char_buf_writer against a cell/cursor reference model.
`timescale 1ns/1ps
module tb_char_buf_writer;

  localparam int BLINK_TB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] char_xy = 8'h00;
  logic [6:0] char_code;
  logic [7:0] cursor_xy;
  logic       busy;

  always #5 clk = ~clk;

`ifdef CHAR_BUF_CURSOR_EN
  char_buf_writer #(.CLEAR_CHAR(7'h20), .CURSOR_GLYPH(7'h7F), .BLINK_DIV(25'd4)) dut (
`else
  char_buf_writer #(.CLEAR_CHAR(7'h20)) dut (
`endif
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .char_xy(char_xy), .char_code(char_code), .cursor_xy(cursor_xy), .busy(busy));

  int tests = 0;
  int fails = 0;

  // reference model: text grid and cursor as row/col
  logic [6:0] mm [256];
  int row = 0;
  int col = 0;
  logic [7:0] exp_q [$];
  int cyc = 0;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) mm[i] = 7'h20;
  endfunction

  function automatic logic [7:0] model_pos();
    return 8'((row << 4) | col);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      mm[row*16 + col] = b[6:0];
      col++;
      if (col == 16) begin col = 0; row = (row + 1) % 16; end
    end else if (b == 8'h0A) begin
      col = 0; row = (row + 1) % 16;
    end else if (b == 8'h0D) begin
      col = 0;
    end else if (b == 8'h08) begin
      if (row != 0 || col != 0) begin
        if (col == 0) begin col = 15; row = row - 1; end
        else col = col - 1;
      end
      mm[row*16 + col] = 7'h20;
    end else if (b == 8'h0C) begin
      row = 0; col = 0;
      model_clear();
    end
  endfunction

  function automatic logic [6:0] model_read(input logic [7:0] a);
`ifdef CHAR_BUF_CURSOR_EN
    if (((cyc / BLINK_TB) % 2 == 1) && a == model_pos()) return 7'h7F;
`endif
    return mm[a];
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    model_byte(b);
    exp_q.push_back(model_pos());
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(32, 126));
  endfunction

  task automatic goto(input logic [7:0] t);
    send(8'h0D);
    while (row != int'(t[7:4])) send(8'h0A);
    repeat (int'(t[3:0])) send(rand_print());
  endtask

  // caller must be positioned at a negedge
  task automatic measure_busy(input string name);
    int n = 0;
    int bad = 0;
    while (busy && n < 400) begin
      if (in_ready) bad++;
      n++;
      @(negedge clk);
    end
    chk({name, " busy cycles"}, n, 256);
    chk({name, " in_ready low while busy"}, bad, 0);
    chk({name, " in_ready after clear"}, int'(in_ready), 1);
  endtask

  task automatic sweep(input string name);
    @(negedge clk);
    for (int a = 0; a < 256; a++) begin
      char_xy = 8'(a);
      #2;
      chk(name, int'({1'b0, char_xy, char_code}), int'({1'b0, 8'(a), model_read(8'(a))}));
    end
  endtask

  // scoreboard monitor: every accepted byte must be followed by the expected cursor
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      if (in_valid && in_ready) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL cursor_xy: got 0x%0h with no byte expected", cursor_xy);
        end else begin
          e = exp_q.pop_front();
          chk("cursor_xy", int'(cursor_xy), int'(e));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int r;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 1);
    chk("reset in_ready", int'(in_ready), 0);
    chk("reset cursor_xy", int'(cursor_xy), 0);
    rst = 1'b0;
    measure_busy("reset");
    sweep("cells after reset");

    send(8'h41);
    send(8'h42);
    sweep("cells after AB");

    send(8'h08);
    send(8'h08);
    repeat (16) send(rand_print());
    repeat (14) send(8'h0A);
    repeat (15) send(rand_print());
    send(8'h5A);
    sweep("cells after wrap");

    goto(8'h35); send(8'h0A);
    goto(8'h35); send(8'h0D);
    goto(8'h12); send(8'h08);
    goto(8'h00); send(8'h08);
    send(8'h85);
    sweep("cells after control codes");

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) b = rand_print();
      else if (r == 6) b = ($urandom_range(0, 1) == 1) ? 8'h0A : 8'h0D;
      else if (r == 7) b = 8'h08;
      else if (r == 8) b = 8'($urandom_range(128, 255));
      else begin
        b = 8'($urandom_range(0, 31));
        if (b == 8'h0C) b = 8'h7F;
      end
      send(b);
    end
    sweep("cells after random stream");

    send(8'h0C);
    @(negedge clk);
    measure_busy("form feed");
    sweep("cells after form feed");

    repeat (20) send(rand_print());
    send(8'h0C);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    row = 0; col = 0;
    chk("cursor after reset mid-clear", int'(cursor_xy), 0);
    measure_busy("reset mid-clear");
    sweep("cells after reset mid-clear");

`ifdef CHAR_BUF_CURSOR_EN
    goto(8'h03);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      char_xy = 8'h03;
      #1 chk("blink cursor cell", int'(char_code), int'(model_read(8'h03)));
      char_xy = 8'h02;
      #1 chk("blink neighbour cell", int'(char_code), int'(model_read(8'h02)));
    end
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
